// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling a synchronised rx line on a 16x oversample tick
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_16x,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 busy
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] sh;
   logic                 rx_m, rx_s;
   logic                 cnt_end, cnt_mid, last_bit;
   assign cnt_end  = cnt == CW'(OVERSAMPLE - 1);
   assign cnt_mid  = cnt == CW'(OVERSAMPLE / 2 - 1);
   assign last_bit = idx == IW'(DATA_BITS - 1);
   assign busy     = state != IDLE;
   // two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end
   // frame FSM: advances only on ticks, strobes self-clear on the next clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         sh            <= '0;
         data          <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         if (tick_16x) begin
            case (state)
               IDLE: if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
               START: if (cnt_mid) begin
                  state <= rx_s ? IDLE : DATA;
                  cnt   <= '0;
                  idx   <= '0;
               end else cnt <= cnt + CW'(1);
               DATA: if (cnt_end) begin
                  sh  <= {rx_s, sh[DATA_BITS-1:1]};
                  cnt <= '0;
                  idx <= idx + IW'(1);
                  if (last_bit) state <= STOP;
               end else cnt <= cnt + CW'(1);
               STOP: if (cnt_end) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data       <= sh;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= BRK;
                  end
               end else cnt <= cnt + CW'(1);
               BRK: if (rx_s) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, tick every 4 clk, one bit = 64 clk
module tb_uart_rx;
   logic       clk = 1'b0, reset = 1'b0, tick_16x = 1'b0, rx = 1'b1;
   logic [7:0] data;
   logic       data_valid, framing_error, busy;
   int         tests = 0, fails = 0;
   bit         tick_en = 1'b0;
   int         div = 0, ticks = 0;
   int         start_t = 0, last_dv = 0;
   bit         pb = 1'b0;
   typedef struct {bit fe; logic [7:0] d; int lat; int gap;} exp_t;
   exp_t       exp_q[$];

   uart_rx dut (
      .clk(clk), .reset(reset), .tick_16x(tick_16x), .rx(rx),
      .data(data), .data_valid(data_valid), .framing_error(framing_error), .busy(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      tick_16x = tick_en && (div == 3);
      div = (div + 1) % 4;
   end

   always @(posedge clk) if (tick_16x) ticks <= ticks + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_pulse(input bit fe, input logic [7:0] d, input int lat, input int gap);
      exp_t e;
      e.fe = fe; e.d = d; e.lat = lat; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      clks(64);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         clks(64);
      end
      rx = stop;
      clks(64);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy && !pb) start_t = ticks;
         pb = busy;
         if (data_valid && framing_error) check("dv_and_fe", 1, 0);
         if (data_valid || framing_error) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {30'd0, data_valid, framing_error}, 0);
            else begin
               e = exp_q.pop_front();
               check(e.fe ? "ferr_kind" : "dv_kind", {31'd0, framing_error}, {31'd0, e.fe});
               check("data", {24'd0, data}, {24'd0, e.d});
               if (e.lat > 0) check("latency", ticks - start_t, e.lat);
               if (e.gap > 0) check("dv_gap", ticks - last_dv, e.gap);
            end
            if (data_valid) last_dv = ticks;
         end
      end
   end

   initial begin : stim
      int hi;
      logic bad;
      reset = 1'b0;
      clks(4);
      check("rst_data", {24'd0, data}, 0);
      check("rst_dv", {31'd0, data_valid}, 0);
      check("rst_fe", {31'd0, framing_error}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (i % 7 == 0) rx = ~rx;
         @(negedge clk);
         bad = bad | busy | data_valid | framing_error | (|data);
      end
      check("no_tick_quiet", {31'd0, bad}, 0);
      rx = 1'b1;
      clks(4);
      tick_en = 1'b1;
      clks(64);
      expect_pulse(1'b0, 8'hA5, 152, 0);
      send(8'hA5, 1'b1);
      clks(128);
      expect_pulse(1'b0, 8'h00, 152, 0);
      expect_pulse(1'b0, 8'hFF, 152, 160);
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      clks(128);
      hi = 0;
      rx = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy) hi++;
      end
      rx = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) hi++;
      end
      check("glitch_busy_clks", hi, 32);
      check("glitch_idle", {31'd0, busy}, 0);
      expect_pulse(1'b1, 8'hFF, 152, 0);
      send(8'h3C, 1'b0);
      clks(40 * 64);
      check("break_busy", {31'd0, busy}, 1);
      rx = 1'b1;
      clks(128);
      check("break_exit", {31'd0, busy}, 0);
      expect_pulse(1'b0, 8'h81, 152, 0);
      send(8'h81, 1'b1);
      clks(128);
      rx = 1'b0;
      clks(64);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         clks(64);
      end
      rx = 1'b1;
      clks(32);
      #2 reset = 1'b0;
      #1;
      check("async_rst_data", {24'd0, data}, 0);
      check("async_rst_dv", {31'd0, data_valid}, 0);
      check("async_rst_fe", {31'd0, framing_error}, 0);
      check("async_rst_busy", {31'd0, busy}, 0);
      @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      clks(128);
      check("post_rst_idle", {31'd0, busy}, 0);
      expect_pulse(1'b0, 8'h5A, 152, 0);
      send(8'h5A, 1'b1);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the 16x oversample tick from baud_gen and deserialises an asynchronous 8N1 serial line into parallel bytes.
- Sits on the receive side of the section-2 UART, the counterpart to the transmit path driven by baud_tick.
- Outputs a one-cycle data_valid strobe per good frame and a one-cycle framing_error strobe per bad stop bit.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 16, tick_16x pulses per bit period; sample counter width is clog2(OVERSAMPLE)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
tick_16x  input  1  one-clk-wide pulse at OVERSAMPLE x baud, from baud_gen
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last correctly received byte
data_valid  output  1  one-clk pulse: data updated with a new byte
framing_error  output  1  one-clk pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE, sample counter cnt=0, bit index=0, shift register=0, data=0, data_valid=0, framing_error=0. The rx synchroniser flops are set to 1. Reset mid-frame abandons the frame with no pulse.
- rx passes through a 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s.
- State, cnt and bit index change only on clk edges where tick_16x==1. The exceptions are the strobes, which clear on the next clk.
- IDLE: on a tick with rx_s==0, go to START with cnt=0.
- START: each tick, cnt++. On the tick where cnt==OVERSAMPLE/2-1 (7):
  - rx_s==0: go to DATA, cnt=0, bit index=0.
  - rx_s==1: treat as a glitch and return to IDLE. No strobe.
- DATA: each tick, if cnt==OVERSAMPLE-1 then sample rx_s into the shift register MSB (right shift, so LSB-first order is preserved), cnt=0, bit index++. Otherwise cnt++. After sampling bit DATA_BITS-1, go to STOP.
- STOP: same 16-tick timing. At the sample point:
  - rx_s==1: data<=shift register, data_valid=1 for exactly one clk, go to IDLE.
  - rx_s==0: framing_error=1 for exactly one clk, data unchanged, go to BREAK.
- BREAK: wait for a tick with rx_s==1, then go to IDLE. This prevents a held-low line (break) from re-triggering frames.
- Latency: the data_valid edge is the clk edge of the tick exactly 8+16*DATA_BITS+16 = 152 ticks after the start-detect tick (default parameters). data_valid and framing_error are never high together.
- A new start bit is accepted on the first tick after returning to IDLE. Back-to-back frames with a one-bit stop therefore work without loss.
- If tick_16x never pulses, no state advances. Only the synchroniser follows rx.
- busy is combinational from state. It is 0 in IDLE, including the cycle data_valid is high.

Test Plan:
- Tick every 4 clk; send 0xA5 with a valid stop bit -> data=0xA5, one data_valid pulse, framing_error stays 0, pulse 152 ticks after the detect tick.
- Back-to-back 0x00 then 0xFF, stop bit of exactly 16 ticks, no idle gap -> two data_valid pulses 160 ticks apart, data=0x00 then 0xFF.
- rx low for 3 ticks then high -> busy rises then falls within 8 ticks; no data_valid, no framing_error.
- Send 0x3C with the stop bit low, then hold rx low 40 more bit-times -> one framing_error pulse, data keeps its prior value, busy stays high (BREAK). After rx returns high, a 0x81 frame gives data=0x81 with data_valid.
- Assert reset low during data bit 4 of a frame -> outputs 0 and busy 0 asynchronously. After release and idle line, frame 0x5A is received correctly.
- Hold tick_16x at 0 while toggling rx -> busy, data, data_valid and framing_error all stay 0.
